// File: rtl/bitstream_serial_loader_if.sv
// Byte-stream, control and serial configuration signals of bitstream_serial_loader.
// The source side uses the master modport and the loader uses the slave modport.
interface bitstream_serial_loader_if #(
   parameter int unsigned WCNT_W = 13
) ();
   logic              start;
   logic              abort;
   logic [WCNT_W-1:0] num_words;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              s_clk;
   logic              s_data;
   logic              busy;
   logic              done;
   logic              underrun;

   modport master (
      output start, abort, num_words, in_data, in_valid,
      input  in_ready, s_clk, s_data, busy, done, underrun
   );

   modport slave (
      input  start, abort, num_words, in_data, in_valid,
      output in_ready, s_clk, s_data, busy, done, underrun
   );
endinterface

// File: rtl/bitstream_serial_loader.sv
// Packs a byte stream into 32-bit words and shifts them into the eFPGA serial config port,
// interleaving each data bit with one control-word bit around the s_clk pulse.
module bitstream_serial_loader #(
   parameter logic [31:0] CTRL_WORD    = 32'h0000FAB1,
   parameter int unsigned PHASE_CYCLES = 1,
   parameter int unsigned WCNT_W       = 13
) (
   input logic CLK,
   input logic resetn,
   bitstream_serial_loader_if.slave bus
);
   localparam int unsigned BCNT_W = WCNT_W + 2;
   localparam int unsigned PCNT_W = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   localparam logic [PCNT_W-1:0] PHASE_LAST = PCNT_W'(PHASE_CYCLES - 1);
   localparam logic [2:0]        PH_LAST    = 3'd4;
   localparam logic [4:0]        BIT_LAST   = 5'd31;

   logic [1:0]        state, state_n;
   logic [WCNT_W-1:0] words_left, words_left_n;
   logic [BCNT_W-1:0] bytes_left, bytes_left_n;
   logic [31:0]       pbuf, pbuf_n;
   logic [1:0]        byte_idx, byte_idx_n;
   logic              pbuf_full, pbuf_full_n;
   logic [31:0]       shreg, shreg_n;
   logic [4:0]        bit_idx, bit_idx_n;
   logic [2:0]        phase, phase_n;
   logic [PCNT_W-1:0] phase_cnt, phase_cnt_n;
   logic              s_clk_q, s_clk_n;
   logic              s_data_q, s_data_n;
   logic              busy_q, busy_n;
   logic              done_q, done_n;
   logic              underrun_q, underrun_n;

   logic              accept;
   logic              load;
   logic              emit;
   logic [31:0]       pbuf_merged;
   logic [4:0]        nxt_bit;
   logic [2:0]        nxt_phase;

   // Ready depends only on registered state so the source sees no combinational loop.
   assign bus.in_ready = (state != ST_IDLE) && !pbuf_full && (bytes_left != '0);
   assign accept       = bus.in_valid && bus.in_ready;

   assign bus.s_clk    = s_clk_q;
   assign bus.s_data   = s_data_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.underrun = underrun_q;

   // Next-state and next-output logic.
   always_comb begin
      state_n      = state;
      words_left_n = words_left;
      bytes_left_n = bytes_left;
      pbuf_n       = pbuf;
      byte_idx_n   = byte_idx;
      pbuf_full_n  = pbuf_full;
      shreg_n      = shreg;
      phase_cnt_n  = phase_cnt;
      s_clk_n      = s_clk_q;
      s_data_n     = s_data_q;
      busy_n       = busy_q;
      done_n       = 1'b0;
      underrun_n   = underrun_q;
      load         = 1'b0;
      emit         = 1'b0;
      nxt_bit      = bit_idx;
      nxt_phase    = phase;
      pbuf_merged  = pbuf;

      // Byte packer: first byte of a word lands in the MSB lane.
      if (accept) begin
         case (byte_idx)
            2'd0:    pbuf_merged[31:24] = bus.in_data;
            2'd1:    pbuf_merged[23:16] = bus.in_data;
            2'd2:    pbuf_merged[15:8]  = bus.in_data;
            default: pbuf_merged[7:0]   = bus.in_data;
         endcase
         pbuf_n       = pbuf_merged;
         byte_idx_n   = byte_idx + 2'd1;
         bytes_left_n = bytes_left - BCNT_W'(1);
         if (byte_idx == 2'd3) pbuf_full_n = 1'b1;
      end

      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               underrun_n = 1'b0;
               if (bus.num_words == '0) begin
                  done_n = 1'b1;
               end else begin
                  state_n      = ST_STALL;
                  words_left_n = bus.num_words;
                  bytes_left_n = {bus.num_words, 2'b00};
                  busy_n       = 1'b1;
                  pbuf_full_n  = 1'b0;
                  byte_idx_n   = 2'd0;
               end
            end
         end
         ST_STALL: begin
            s_clk_n  = 1'b0;
            s_data_n = 1'b0;
            // Load as soon as the word is complete, including the edge that delivers its last byte.
            if (pbuf_full || (accept && (byte_idx == 2'd3))) load = 1'b1;
         end
         ST_RUN: begin
            if (phase_cnt != PHASE_LAST) begin
               phase_cnt_n = phase_cnt + PCNT_W'(1);
            end else begin
               phase_cnt_n = '0;
               if (phase != PH_LAST) begin
                  nxt_phase = phase + 3'd1;
                  emit      = 1'b1;
               end else if (bit_idx != BIT_LAST) begin
                  nxt_bit   = bit_idx + 5'd1;
                  nxt_phase = 3'd0;
                  emit      = 1'b1;
               end else begin
                  words_left_n = words_left - WCNT_W'(1);
                  if (words_left == WCNT_W'(1)) begin
                     state_n  = ST_IDLE;
                     done_n   = 1'b1;
                     busy_n   = 1'b0;
                     s_clk_n  = 1'b0;
                     s_data_n = 1'b0;
                  end else if (pbuf_full) begin
                     load = 1'b1;
                  end else begin
                     state_n    = ST_STALL;
                     underrun_n = 1'b1;
                     s_clk_n    = 1'b0;
                     s_data_n   = 1'b0;
                  end
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      if (load) begin
         shreg_n     = pbuf_merged;
         pbuf_full_n = 1'b0;
         state_n     = ST_RUN;
         nxt_bit     = 5'd0;
         nxt_phase   = 3'd0;
         phase_cnt_n = '0;
         emit        = 1'b1;
      end

      bit_idx_n = nxt_bit;
      phase_n   = nxt_phase;

      // Phases 0-1 carry the data bit, 2-4 the control bit; s_clk is high in phases 1-2.
      if (emit) begin
         s_clk_n  = (nxt_phase == 3'd1) || (nxt_phase == 3'd2);
         s_data_n = (nxt_phase < 3'd2) ? shreg_n[~nxt_bit] : CTRL_WORD[~nxt_bit];
      end

      if (bus.abort) begin
         state_n      = ST_IDLE;
         s_clk_n      = 1'b0;
         s_data_n     = 1'b0;
         busy_n       = 1'b0;
         done_n       = 1'b0;
         pbuf_n       = '0;
         pbuf_full_n  = 1'b0;
         byte_idx_n   = 2'd0;
         bytes_left_n = '0;
         words_left_n = '0;
      end
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         words_left <= '0;
         bytes_left <= '0;
         pbuf       <= '0;
         byte_idx   <= '0;
         pbuf_full  <= 1'b0;
         shreg      <= '0;
         bit_idx    <= '0;
         phase      <= '0;
         phase_cnt  <= '0;
         s_clk_q    <= 1'b0;
         s_data_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state      <= state_n;
         words_left <= words_left_n;
         bytes_left <= bytes_left_n;
         pbuf       <= pbuf_n;
         byte_idx   <= byte_idx_n;
         pbuf_full  <= pbuf_full_n;
         shreg      <= shreg_n;
         bit_idx    <= bit_idx_n;
         phase      <= phase_n;
         phase_cnt  <= phase_cnt_n;
         s_clk_q    <= s_clk_n;
         s_data_q   <= s_data_n;
         busy_q     <= busy_n;
         done_q     <= done_n;
         underrun_q <= underrun_n;
      end
   end
endmodule

// File: tb/tb_bitstream_serial_loader.sv
// Bench for bitstream_serial_loader: random byte streams checked against a word-level model
// built from the serial waveform (data sampled at s_clk rises, control at falls).
module tb_bitstream_serial_loader;
   localparam int unsigned WCNT_W = 13;
   localparam logic [31:0] CTRL   = 32'h0000FAB1;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bitstream_serial_loader_if #(.WCNT_W(WCNT_W)) b1 ();
   bitstream_serial_loader_if #(.WCNT_W(WCNT_W)) b3 ();

   bitstream_serial_loader #(.CTRL_WORD(CTRL), .PHASE_CYCLES(1), .WCNT_W(WCNT_W)) u_dut1 (
      .CLK(clk), .resetn(rst_n), .bus(b1));
   bitstream_serial_loader #(.CTRL_WORD(CTRL), .PHASE_CYCLES(3), .WCNT_W(WCNT_W)) u_dut3 (
      .CLK(clk), .resetn(rst_n), .bus(b3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Byte source for the PHASE_CYCLES=1 instance.
   logic [7:0] feed_q[$];
   logic [7:0] stim_q[$];
   int   allowed = 0;
   int   acc_cnt = 0;
   int   acc_edge_cyc = 0;
   int   valid_pct = 100;
   logic will_acc = 1'b0;

   initial forever begin
      @(negedge clk);
      if (will_acc && feed_q.size() > 0) begin
         void'(feed_q.pop_front());
         acc_cnt++;
         acc_edge_cyc = cyc;
      end
      b1.in_valid = (feed_q.size() > 0) && (acc_cnt < allowed) && ($urandom_range(99) < valid_pct);
      b1.in_data  = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
      will_acc    = b1.in_valid && b1.in_ready;
   end

   // Byte source for the PHASE_CYCLES=3 instance, always valid.
   logic [7:0] feed3_q[$];
   logic will3 = 1'b0;

   initial forever begin
      @(negedge clk);
      if (will3 && feed3_q.size() > 0) void'(feed3_q.pop_front());
      b3.in_valid = feed3_q.size() > 0;
      b3.in_data  = (feed3_q.size() > 0) ? feed3_q[0] : 8'h00;
      will3       = b3.in_valid && b3.in_ready;
   end

   // Serial monitors: data bits at s_clk rises, control bits at s_clk falls.
   logic rise_q1[$], fall_q1[$], rise_q3[$];
   int   rise_c1[$], rise_c3[$], fall_c3[$];
   logic p1 = 1'b0, p3 = 1'b0;
   int   done_cnt1 = 0;

   always @(negedge clk) begin
      if (!p1 && b1.s_clk) begin rise_q1.push_back(b1.s_data); rise_c1.push_back(cyc); end
      if (p1 && !b1.s_clk) fall_q1.push_back(b1.s_data);
      p1 = b1.s_clk;
      if (b1.done) done_cnt1++;
      if (!p3 && b3.s_clk) begin rise_q3.push_back(b3.s_data); rise_c3.push_back(cyc); end
      if (p3 && !b3.s_clk) fall_c3.push_back(cyc);
      p3 = b3.s_clk;
   end

   function automatic logic [31:0] word_of(input logic q[$], input int w);
      logic [31:0] r = '0;
      for (int i = 0; i < 32; i++)
         r = {r[30:0], ((w * 32 + i) < q.size()) ? q[w * 32 + i] : 1'b0};
      return r;
   endfunction

   function automatic logic [31:0] exp_word(input int w);
      return {stim_q[4 * w], stim_q[4 * w + 1], stim_q[4 * w + 2], stim_q[4 * w + 3]};
   endfunction

   task automatic clear_mon();
      rise_q1.delete(); fall_q1.delete(); rise_c1.delete();
      done_cnt1 = 0;
      acc_cnt   = 0;
   endtask

   task automatic start1(input int n);
      @(negedge clk);
      b1.num_words = WCNT_W'(n);
      b1.start     = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      check("start_busy_ready", 32'({b1.busy, b1.in_ready}), 32'h3);
   endtask

   task automatic wait_done(input string tag, input int limit, output int dcyc);
      int k = 0;
      while (k < limit && !b1.done) begin @(negedge clk); k++; end
      dcyc = cyc;
      check({tag, "_done_busy_sclk"}, 32'({b1.done, b1.busy, b1.s_clk}), 32'h4);
   endtask

   task automatic wait_rises(input string tag, input int n, input int limit);
      int k = 0;
      while (k < limit && rise_q1.size() < n) begin @(negedge clk); k++; end
      check({tag, "_reach_rises"}, 32'(rise_q1.size() >= n), 32'h1);
   endtask

   task automatic rand_stim(input int nbytes);
      stim_q.delete();
      for (int i = 0; i < nbytes; i++) stim_q.push_back(8'($urandom_range(255)));
   endtask

   // Full load of n words from stim_q; 4 surplus bytes are offered and must never be taken.
   task automatic run_check(input string tag, input int n, input int pct, input int restart_at,
                            output int dcyc);
      clear_mon();
      allowed   = 1 << 30;
      valid_pct = pct;
      feed_q    = stim_q;
      for (int i = 0; i < 4; i++) feed_q.push_back(8'($urandom_range(255)));
      start1(n);
      if (restart_at > 0) begin
         repeat (restart_at) @(negedge clk);
         b1.num_words = WCNT_W'(5);
         b1.start     = 1'b1;
         @(negedge clk);
         b1.start = 1'b0;
      end
      wait_done(tag, 4000, dcyc);
      check({tag, "_rises"}, 32'(rise_q1.size()), 32'(32 * n));
      for (int w = 0; w < n; w++) begin
         check({tag, "_data"}, word_of(rise_q1, w), exp_word(w));
         check({tag, "_ctrl"}, word_of(fall_q1, w), CTRL);
      end
      repeat (2) @(negedge clk);
      check({tag, "_bytes_taken"}, 32'(acc_cnt), 32'(4 * n));
      check({tag, "_done_count"}, 32'(done_cnt1), 32'h1);
      feed_q.delete();
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcyc;
      int bad;
      logic nz;
      b1.start = 1'b0; b1.abort = 1'b0; b1.num_words = '0;
      b3.start = 1'b0; b3.abort = 1'b0; b3.num_words = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_outputs", 32'({b1.busy, b1.done, b1.s_clk, b1.s_data, b1.underrun, b1.in_ready}), 32'h0);

      // Single word with fixed bytes.
      stim_q = '{8'hA5, 8'h0F, 8'h00, 8'hFF};
      run_check("single", 1, 100, 0, dcyc);
      check("single_word", word_of(rise_q1, 0), 32'hA50F00FF);
      check("single_first_p0", 32'(rise_c1[0] - 1), 32'(acc_edge_cyc));
      check("single_done_latency", 32'(dcyc - (rise_c1[0] - 1)), 32'd160);
      check("single_underrun", 32'(b1.underrun), 32'h0);

      // Back-to-back words with a continuously valid source.
      rand_stim(12);
      run_check("b2b", 3, 100, 0, dcyc);
      bad = 0;
      for (int i = 1; i < rise_c1.size(); i++) if (rise_c1[i] - rise_c1[i-1] != 5) bad++;
      check("b2b_period", 32'(bad), 32'h0);
      check("b2b_duration", 32'(dcyc - (rise_c1[0] - 1)), 32'd480);
      check("b2b_underrun", 32'(b1.underrun), 32'h0);

      // Starved source: second word's bytes arrive 300 cycles late.
      rand_stim(8);
      clear_mon();
      allowed = 4; valid_pct = 100; feed_q = stim_q;
      start1(2);
      wait_rises("starve", 32, 1000);
      repeat (10) @(negedge clk);
      nz = 1'b0;
      repeat (290) begin @(negedge clk); nz = nz | b1.s_clk | b1.s_data | !b1.busy; end
      check("starve_gap_quiet", 32'(nz), 32'h0);
      check("starve_underrun", 32'(b1.underrun), 32'h1);
      allowed = 8;
      wait_done("starve", 1000, dcyc);
      check("starve_rises", 32'(rise_q1.size()), 32'd64);
      check("starve_word0", word_of(rise_q1, 0), exp_word(0));
      check("starve_word1", word_of(rise_q1, 1), exp_word(1));
      check("starve_ctrl1", word_of(fall_q1, 1), CTRL);
      check("starve_underrun_sticky", 32'(b1.underrun), 32'h1);
      repeat (2) @(negedge clk);
      feed_q.delete();

      // Abort at bit 10 of word 0, then a clean single-word load.
      rand_stim(8);
      clear_mon();
      allowed = 1 << 30; feed_q = stim_q;
      start1(2);
      wait_rises("abort", 11, 1000);
      b1.abort = 1'b1;
      @(negedge clk);
      b1.abort = 1'b0;
      check("abort_outputs", 32'({b1.busy, b1.s_clk, b1.s_data, b1.in_ready}), 32'h0);
      repeat (300) @(negedge clk);
      check("abort_no_done", 32'(done_cnt1), 32'h0);
      feed_q.delete();
      rand_stim(4);
      run_check("post_abort", 1, 100, 0, dcyc);
      check("post_abort_underrun", 32'(b1.underrun), 32'h0);

      // Reset pulsed mid-load, then a clean single-word load.
      rand_stim(8);
      clear_mon();
      feed_q = stim_q;
      start1(2);
      wait_rises("rst", 11, 1000);
      rst_n = 1'b0;
      #1;
      check("reset_async_outputs", 32'({b1.busy, b1.s_clk, b1.s_data, b1.done}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("reset_no_done", 32'(done_cnt1), 32'h0);
      feed_q.delete();
      rand_stim(4);
      run_check("post_reset", 1, 100, 0, dcyc);

      // Zero-word request.
      @(negedge clk);
      b1.num_words = '0;
      b1.start     = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      check("zero_done", 32'({b1.done, b1.busy}), 32'h2);
      @(negedge clk);
      check("zero_done_pulse", 32'({b1.done, b1.busy}), 32'h0);

      // Start while busy must be ignored.
      rand_stim(8);
      run_check("restart_ignored", 2, 100, 50, dcyc);

      // Randomized lengths and source throttling.
      for (int it = 0; it < 4; it++) begin
         int n;
         n = $urandom_range(1, 3);
         rand_stim(4 * n);
         run_check("rand", n, $urandom_range(30, 90), 0, dcyc);
      end

      // Slow phases on the PHASE_CYCLES=3 instance.
      stim_q.delete();
      for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom_range(255)));
      feed3_q = stim_q;
      @(negedge clk);
      b3.num_words = WCNT_W'(1);
      b3.start     = 1'b1;
      @(negedge clk);
      b3.start = 1'b0;
      begin
         int k = 0;
         while (k < 2000 && !b3.done) begin @(negedge clk); k++; end
      end
      dcyc = cyc;
      check("slow_done", 32'({b3.done, b3.busy}), 32'h2);
      check("slow_rises", 32'(rise_q3.size()), 32'd32);
      check("slow_word", word_of(rise_q3, 0), exp_word(0));
      bad = 0;
      for (int i = 0; i < rise_c3.size() && i < fall_c3.size(); i++)
         if (fall_c3[i] - rise_c3[i] != 6) bad++;
      for (int i = 1; i < rise_c3.size(); i++) if (rise_c3[i] - rise_c3[i-1] != 15) bad++;
      check("slow_high6_period15", 32'(bad), 32'h0);
      check("slow_duration", 32'(dcyc - (rise_c3[0] - 3)), 32'd480);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
